// File: rtl/uart_cmd_responder.sv
// Host command responder: parses SOF/CMD/ADDR[/DATA] frames from the UART RX stream,
// drives a single-byte register bus and returns RSP/payload (or NAK) frames on UART TX.
module uart_cmd_responder #(
    parameter int          DATA_WIDTH     = 8,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter logic [7:0]  RSP_BYTE       = 8'h5A,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [7:0]            reg_rdata,
    output logic                  err,
    output logic                  busy
);

    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;
    localparam int         TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_REG_WR,
        S_REG_RD,
        S_RD_WAIT,
        S_TX_HDR,
        S_TX_PAY,
        S_TX_NAK
    } state_t;

    state_t        state;
    logic          is_write;
    logic [7:0]    payload;
    logic [TW-1:0] idle_cnt;
    logic          in_frame;
    logic          rx_fire;
    logic          tx_fire;
    logic          timeout;

    assign in_frame = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
    assign rx_ready = rst_n && ((state == S_IDLE) || in_frame);
    assign busy     = (state != S_IDLE);
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    // An accepted byte on the expiry cycle still counts: the frame keeps going.
    assign timeout  = in_frame && !rx_fire && (idle_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            is_write  <= 1'b0;
            payload   <= '0;
            idle_cnt  <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            err       <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            err    <= 1'b0;

            if (in_frame && !rx_fire)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;

            if (timeout) begin
                state <= S_IDLE;
                err   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_fire && rx_data == SOF_BYTE)
                            state <= S_CMD;
                    end
                    S_CMD: begin
                        if (rx_fire) begin
                            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                                is_write <= (rx_data == CMD_WR);
                                state    <= S_ADDR;
                            end else begin
                                err      <= 1'b1;
                                tx_valid <= 1'b1;
                                tx_data  <= NAK_BYTE;
                                state    <= S_TX_NAK;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (rx_fire) begin
                            reg_addr <= rx_data;
                            if (is_write) begin
                                state <= S_DATA;
                            end else begin
                                reg_re <= 1'b1;
                                state  <= S_REG_RD;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_fire) begin
                            reg_wdata <= rx_data;
                            reg_we    <= 1'b1;
                            state     <= S_REG_WR;
                        end
                    end
                    S_REG_WR: begin
                        payload  <= ACK_BYTE;
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_BYTE;
                        state    <= S_TX_HDR;
                    end
                    S_REG_RD: begin
                        state <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        payload  <= reg_rdata;
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_BYTE;
                        state    <= S_TX_HDR;
                    end
                    S_TX_HDR: begin
                        if (tx_fire) begin
                            tx_data <= payload;
                            state   <= S_TX_PAY;
                        end
                    end
                    S_TX_PAY, S_TX_NAK: begin
                        if (tx_fire) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            state    <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
